// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan controller.
//   state_e       : controller FSM states (SCAN, DEBOUNCE, HELD, RELEASE)
//   ROW_IDLE      : row pattern with no key pressed (rows are active-low)
//   row_to_index  : lowest-index low row bit -> 2-bit row number
//   cnt_w         : counter width for a given maximum count (at least 1 bit)
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  function automatic logic [1:0] row_to_index(input logic [3:0] row_pat);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_pat[i] && !found) begin
        idx   = i[1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
//   clk    : system clock
//   reset  : synchronous active-high reset (outputs idle rows)
//   d_i    : raw row inputs
//   q_o    : synchronized rows
module key_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= ROW_IDLE;
      sync_q <= ROW_IDLE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with debounce and a one-entry key holding register.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   row          : keypad rows, active-low, asynchronous
//   col          : column drive, active-low one-hot
//   key_code     : code (4*row + col) of the most recently accepted key
//   key_valid    : key_code holds an unconsumed key
//   key_ack      : consumer takes the key this clock
//   key_overrun  : sticky, a key was accepted over an unconsumed one
//   busy         : FSM is outside SCAN
// Optional feature: define KEYPAD_REPEAT_EN to re-issue the held key every
// REPEAT_CYC clocks.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CYC = 64,
  parameter int unsigned REPEAT_CYC   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_overrun,
  output logic       busy
);

  if (SCAN_DIV < 4 || DEBOUNCE_CYC == 0 || REPEAT_CYC == 0) begin : g_param_check
    $error("keypad_scan_ctrl: illegal parameter value");
  end

  localparam int unsigned DIV_W = cnt_w(SCAN_DIV);
  localparam int unsigned DEB_W = cnt_w(DEBOUNCE_CYC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

  logic [3:0] row_s;

  key_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (row),
    .q_o   (row_s)
  );

  state_e           state_q,   state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [DEB_W-1:0] deb_q,     deb_d;
  logic [1:0]       r_q,       r_d;
  logic [3:0]       pat_q,     pat_d;
  logic [3:0]       code_q,    code_d;
  logic             valid_q,   valid_d;
  logic             ovr_q,     ovr_d;
  logic             accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = cnt_w(REPEAT_CYC);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    div_d     = div_q;
    deb_d     = deb_q;
    r_d       = r_q;
    pat_d     = pat_q;
    accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif

    unique case (state_q)
      ST_SCAN: begin
        // Rows are only judged on the last clock of a step so the
        // synchronizer has settled on the current column.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (row_s != ROW_IDLE) begin
            r_d     = row_to_index(row_s);
            pat_d   = row_s;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (row_s != pat_q) begin
          deb_d   = '0;
          div_d   = '0;
          state_d = ST_SCAN;
        end else if (deb_q == DEB_LAST) begin
          accept  = 1'b1;
          deb_d   = '0;
          state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      ST_HELD: begin
        if (row_s == ROW_IDLE) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          accept = 1'b1;
          rep_d  = '0;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
`endif
      end

      ST_RELEASE: begin
        if (row_s != ROW_IDLE) begin
          deb_d   = '0;
          state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else if (deb_q == DEB_LAST) begin
          deb_d     = '0;
          div_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = ST_SCAN;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  // Key holding register: a new key always wins; ack only clears when no
  // key arrives on the same clock.
  always_comb begin
    code_d  = accept ? {r_q, col_idx_q} : code_q;
    valid_d = accept ? 1'b1 : (key_ack ? 1'b0 : valid_q);
    ovr_d   = ovr_q | (accept & valid_q & ~key_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      col_idx_q <= '0;
      div_q     <= '0;
      deb_q     <= '0;
      r_q       <= '0;
      pat_q     <= ROW_IDLE;
      code_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      r_q       <= r_d;
      pat_q     <= pat_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign col         = ~(4'b0001 << col_idx_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_overrun = ovr_q;
  assign busy        = (state_q != ST_SCAN);

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SCAN_DIV, 16, clocks each column is driven per scan step; legal values >= 4.
REQ-002 DEBOUNCE_CYC, 64, consecutive stable synced samples needed to accept a press or a release.
REQ-003 REPEAT_CYC, 1024, held clocks between auto-repeat codes; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 row  input  4  keypad rows, active-low, asynchronous to clk.
REQ-007 col  output  4  column drive, active-low one-hot.
REQ-008 key_code  output  4  code of the most recently accepted key.
REQ-009 key_valid  output  1  key_code holds an unconsumed key.
REQ-010 key_ack  input  1  consumer takes the key on this clock.
REQ-011 key_overrun  output  1  sticky flag: a key was accepted while key_valid was high and unacked.
REQ-012 busy  output  1  high whenever the FSM is not in SCAN.

Function
REQ-013 row SHALL pass through a two-flop synchronizer (reset value 4'b1111); all decisions use the synced value.
REQ-014 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN behaviour:
  - drive column c for SCAN_DIV clocks, then advance c; c wraps 3 -> 0.
  - on the last clock of each step, if synced row != 4'b1111, latch r (lowest-index low bit) and c, then go to DEBOUNCE.
  - otherwise advance c.
REQ-016 DEBOUNCE behaviour:
  - col held; count clocks where synced row equals the latched pattern.
  - any mismatch returns to SCAN on the same column with the counter cleared.
  - when the count reaches DEBOUNCE_CYC, accept key_code = 4*r + c and go to HELD.
REQ-017 HELD behaviour: col held; synced row == 4'b1111 goes to RELEASE.
REQ-018 RELEASE behaviour:
  - needs DEBOUNCE_CYC consecutive all-high samples, then go to SCAN at column c+1 (wrapping).
  - any low sample returns to HELD with no new key.
REQ-019 key_valid SHALL rise the clock after acceptance and stay high until key_ack is sampled high; key_ack with key_valid low is ignored.
REQ-020 Acceptance and key_ack on the same clock: load the new code, keep key_valid high, do not set key_overrun.
REQ-021 Acceptance with key_valid high and no key_ack: overwrite key_code and set key_overrun, which stays set until reset.
REQ-022 Counter widths SHALL be $clog2 of their maximum parameter value; counters saturate and never wrap.

Reset
REQ-023 On reset, on the next clock edge:
  - col = 4'b1110, key_code = 0, key_valid = 0, key_overrun = 0, busy = 0.
  - FSM = SCAN, all counters = 0.
REQ-024 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL abandon the key; no key_valid is produced.

Configuration
REQ-025 With KEYPAD_REPEAT_EN defined, HELD SHALL re-accept the same code every REPEAT_CYC clocks under the REQ-019..021 rules.
REQ-026 Without KEYPAD_REPEAT_EN, exactly one code SHALL be produced per debounced press.

Structure
REQ-027 Package keypad_pkg SHALL hold:
  - the state enum,
  - constant ROW_IDLE = 4'b1111,
  - function row_to_index (lowest-low-bit priority encode).
REQ-028 Sub-module key_sync SHALL implement the 4-bit two-flop synchronizer.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=32; the bench models the keypad: row[r] is low only while col[c] is low for pressed key (r,c))
REQ-029 Reset, then rows idle -> col cycles 1110, 1101, 1011, 0111, 1110, each for 4 clocks; key_valid and busy stay 0.
REQ-030 Press (r=1, c=2), stable -> key_code = 4'h6, key_valid = 1 until key_ack; key_valid = 0 one clock after ack; col returns to scanning only after release debounce.
REQ-031 Glitch of 5 clocks on (r=0, c=0) -> no key. Bounce of 3 clocks, then stable -> exactly one key_valid.
REQ-032 Press 4'h6, release, then press (r=3, c=0) with no ack -> key_code = 4'hC, key_overrun = 1 and sticky; ack on the same clock as acceptance -> no overrun.
REQ-033 Reset during DEBOUNCE -> reset values on the next clock; no key_valid.
REQ-034 KEYPAD_REPEAT_EN defined, key held 100 clocks past acceptance, ack every code -> 4 codes total, spaced 32 clocks apart.
